// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - registered N-channel selector with manual select and auto-scan sequencer
module mux_scan_sel #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Mode,
  input  logic [SEL_W-1:0] S,
  input  logic [N_CH-1:0]  D,
  output logic             Y,
  output logic             Yn,
  output logic [SEL_W-1:0] Ch,
  output logic             Frame
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   N_CH_W   = (SEL_W + 1)'(N_CH);

  logic             y_q, y_d;
  logic             yn_q, yn_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             frame_q, frame_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic [SEL_W-1:0] scan_idx;
  logic [CNT_W-1:0] scan_cnt;
  logic             last_cnt;
  logic             sel_ok;

  // Next-state: disable blanks the output but freezes the scan position;
  // entering auto from manual/reset starts channel 0 as if idx/cnt were zero.
  always_comb begin
    y_d      = y_q;
    yn_d     = yn_q;
    ch_d     = ch_q;
    frame_d  = 1'b0;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    scan_idx = mode_q ? idx_q : '0;
    scan_cnt = mode_q ? cnt_q : '0;
    last_cnt = (scan_cnt == LAST_CNT);
    sel_ok   = ({1'b0, S} < N_CH_W);

    if (En) begin
      y_d  = 1'b0;
      yn_d = 1'b1;
    end else if (!Mode) begin
      y_d    = sel_ok ? D[S] : 1'b0;
      yn_d   = sel_ok ? ~D[S] : 1'b1;
      ch_d   = S;
      idx_d  = '0;
      cnt_d  = '0;
      mode_d = 1'b0;
    end else begin
      y_d     = D[scan_idx];
      yn_d    = ~D[scan_idx];
      ch_d    = scan_idx;
      frame_d = (scan_idx == LAST_CH) && last_cnt;
      mode_d  = 1'b1;
      if (last_cnt) begin
        cnt_d = '0;
        idx_d = (scan_idx == LAST_CH) ? '0 : scan_idx + 1'b1;
      end else begin
        cnt_d = scan_cnt + 1'b1;
        idx_d = scan_idx;
      end
    end
  end

  // State register with synchronous reset to the idle/blank state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      y_q     <= 1'b0;
      yn_q    <= 1'b1;
      ch_q    <= '0;
      frame_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      yn_q    <= yn_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign Y     = y_q;
  assign Yn    = yn_q;
  assign Ch    = ch_q;
  assign Frame = frame_q;

endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Parametrised, registered N-channel data selector: successor to the 8:1 74151-style selector. It keeps the active-low enable and the complementary Y/Yn outputs. It adds a clocked output stage and an auto-scan mode, in which an internal sequencer steps through every channel with a programmable dwell time and flags the end of each frame. It sits between parallel status/data lines and serial consumers such as time-division sampling, LED scanning and bit-serial readout.

## Interface
Parameters:
- N_CH, 8: number of data channels, ≥2.
- SEL_W, 3: select/index width; must equal ceil(log2(N_CH)).
- DWELL, 1: cycles each channel is presented in auto-scan, ≥1.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  reset; synchronous, active-high; overrides every other input.
- En  in  1  enable, active-low (En=1 disables, as on the 74151).
- Mode  in  1  0 = manual select via S, 1 = auto-scan.
- S  in  SEL_W  manual channel select; ignored when Mode=1.
- D  in  N_CH  channel data, bit i = channel i.
- Y  out  1  registered selected data.
- Yn  out  1  registered complement of Y.
- Ch  out  SEL_W  channel index that Y currently represents.
- Frame  out  1  one-cycle pulse marking the last sample of a scan frame.

## Operation
- Internal state:
  - idx (SEL_W): scan channel.
  - cnt (ceil(log2(DWELL)) bits, min 1): dwell counter.
  - mode_q: Mode registered; used to detect mode changes.
- Priority per edge: Rst > En=1 > Mode.
- Rst=1:
  - Y=0, Yn=1, Ch=0, Frame=0.
  - idx=0, cnt=0, mode_q=0.
- Disabled (En=1):
  - Y<=0, Yn<=1, Frame<=0.
  - Ch, idx, cnt and mode_q hold, so the scan pauses and resumes where it stopped.
- Manual (En=0, Mode=0):
  - Y<=D[S], Yn<=~D[S], Ch<=S, Frame<=0.
  - idx<=0, cnt<=0.
  - S≥N_CH (non-power-of-2 N_CH): Y<=0, Yn<=1, Ch<=S.
- Auto (En=0, Mode=1):
  - If mode_q=0 (entry from manual or from reset), the scan restarts: Y<=D[0], Ch<=0, and channel 0 begins its dwell.
  - Otherwise Y<=D[idx], Yn<=~D[idx], Ch<=idx.
  - Frame<=1 iff idx==N_CH-1 and cnt==DWELL-1.
  - If cnt==DWELL-1: cnt<=0 and idx<=idx+1, with N_CH-1 wrapping to 0. Else cnt<=cnt+1.
- Y is always exactly ~Yn after every edge.
- D is sampled at the edge, not held; a D change mid-dwell appears on the next edge.

## Timing
- Latency: 1 cycle. Inputs at edge k appear on Y/Yn/Ch/Frame after edge k.
- Auto-scan frame period: N_CH×DWELL cycles. Each Ch value is held DWELL consecutive cycles.
- Frame: exactly one cycle per frame, coincident with the final cycle of Ch=N_CH-1; never asserted in manual or disabled mode.
- Rst released with En=0, Mode=1: first edge yields Ch=0. With DWELL=1, Ch is 0,1,…,N_CH-1,0,…
- Rst asserted mid-scan: outputs return to reset values on the same edge; the scan restarts from channel 0.
- En pulse of length P mid-dwell: outputs Y=0/Yn=1 for P cycles; the remaining dwell count is preserved.
- Mode 1→0: manual output on the next edge; the scan position is discarded.
- Mode toggled while En=1: no effect until En=0. mode_q holds, so entry is judged against the mode in force before the disable.

## Test plan
1. Reset: Rst=1 for 2 cycles, D=8'hFF, En=0, Mode=1 → Y=0, Yn=1, Ch=0, Frame=0 throughout.
2. Manual select, N_CH=8:
   - En=0, Mode=0, S=2, D=8'b00000100 → next edge Y=1, Yn=0, Ch=2.
   - Then S=3, D unchanged → Y=0, Yn=1, Ch=3.
3. Disable: En=1, S=0, D=8'b00000001 → Y=0, Yn=1, Frame=0. Re-enable → Y=1 one edge later.
4. Auto-scan, DWELL=1: D=8'b10100101, Mode=1, En=0 → Y sequence 1,0,1,0,0,1,0,1 with Ch 0..7. Frame=1 only on the Ch=7 cycle; Ch wraps to 0 on the next cycle, period 8.
5. Pause/resume: during auto-scan, En=1 for 3 cycles right after Ch=3 is shown → Y=0, Yn=1, Ch stays 3. En=0 → next Ch=4, with no channel skipped or repeated.
6. Instance N_CH=5, DWELL=3, SEL_W=3:
   - Auto-scan → each Ch held 3 cycles. Frame on the 3rd cycle of Ch=4; period 15.
   - Mode=0, S=6 → Y=0, Yn=1, Ch=6.
   - Rst pulse mid-frame → Ch=0, scan restarts.
